binary_to_bcd_seq_ctrl: RTL

//  Multi-cycle binary-to-BCD conversion engine with valid/ready handshakes on both sides.

---
 rtl/binary_to_bcd_seq_ctrl_if.sv | 43 ++++
 rtl/binary_to_bcd_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq_ctrl_if.sv
//==============================================================================
// Module      : binary_to_bcd_seq_ctrl_if
// Description : Producer-side and consumer-side handshakes of the BCD converter.
//               Optional macro: BCD_LZ_BLANK_EN adds the out_blank field.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface binary_to_bcd_seq_ctrl_if #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      in_binary;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   out_bcd;
   logic                  out_ovf;
`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0]     out_blank;

   modport master (
      output in_valid, in_binary, out_ready,
      input  in_ready, out_valid, out_bcd, out_ovf, out_blank
   );
   modport slave (
      input  in_valid, in_binary, out_ready,
      output in_ready, out_valid, out_bcd, out_ovf, out_blank
   );
`else
   modport master (
      output in_valid, in_binary, out_ready,
      input  in_ready, out_valid, out_bcd, out_ovf
   );
   modport slave (
      input  in_valid, in_binary, out_ready,
      output in_ready, out_valid, out_bcd, out_ovf
   );
`endif
endinterface

`default_nettype wire

// File: rtl/binary_to_bcd_seq_ctrl.sv
//==============================================================================
// Module      : binary_to_bcd_seq_ctrl
// Description : Sequential double-dabble binary-to-BCD converter, one bit per clock.
//               Optional macro: BCD_LZ_BLANK_EN enables leading-zero blanking flags.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module binary_to_bcd_seq_ctrl #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  wire logic                 clk,
   input  wire logic                 reset_n,
   binary_to_bcd_seq_ctrl_if.slave   bus
);

   localparam int c_bcd_w = 4 * DIGITS;
   localparam int c_reg_w = c_bcd_w + BIN_W;
   localparam int c_cnt_w = $clog2(BIN_W + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(BIN_W);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t               state_q,     state_d;
   logic [c_reg_w-1:0]   sr_q,        sr_d;
   logic [c_cnt_w-1:0]   cnt_q,       cnt_d;
   logic                 ovf_q,       ovf_d;
   logic                 in_ready_q,  in_ready_d;
   logic                 out_valid_q, out_valid_d;
   logic [c_bcd_w-1:0]   out_bcd_q,   out_bcd_d;
   logic                 out_ovf_q,   out_ovf_d;

   logic [c_reg_w-1:0]   w_adj;
   logic [c_reg_w-1:0]   w_shifted;
   logic                 w_fin_ovf;
   logic [c_bcd_w-1:0]   w_fin_bcd;

`ifdef BCD_LZ_BLANK_EN
   logic [DIGITS-1:0]    out_blank_q, out_blank_d;
   logic [DIGITS-1:0]    w_blank;
   logic                 w_zero_above;
`endif

   // Adjust-then-shift datapath; digits occupy the register bits above the binary field
   always_comb begin
      w_adj = sr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (sr_q[BIN_W+4*i +: 4] >= 4'd5)
            w_adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
      end
      w_shifted = {w_adj[c_reg_w-2:0], 1'b0};
      w_fin_ovf = ovf_q | w_adj[c_reg_w-1];
      w_fin_bcd = w_shifted[c_reg_w-1 -: c_bcd_w];
   end

`ifdef BCD_LZ_BLANK_EN
   // Digit 0 is never blanked so that zero still shows one digit
   always_comb begin
      w_blank      = '0;
      w_zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         w_zero_above = w_zero_above & (w_fin_bcd[4*i +: 4] == 4'd0);
         w_blank[i]   = w_zero_above;
      end
      if (w_fin_ovf)
         w_blank = '0;
   end
`endif

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_bcd_d   = out_bcd_q;
      out_ovf_d   = out_ovf_q;
`ifdef BCD_LZ_BLANK_EN
      out_blank_d = out_blank_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               sr_d       = {{c_bcd_w{1'b0}}, bus.in_binary};
               cnt_d      = c_cnt_load;
               ovf_d      = 1'b0;
               in_ready_d = 1'b0;
               state_d    = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            sr_d  = w_shifted;
            ovf_d = w_fin_ovf;
            cnt_d = cnt_q - c_cnt_one;
            if (cnt_q == c_cnt_one) begin
               state_d     = ST_DONE;
               out_valid_d = 1'b1;
               out_bcd_d   = w_fin_bcd;
               out_ovf_d   = w_fin_ovf;
`ifdef BCD_LZ_BLANK_EN
               out_blank_d = w_blank;
`endif
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_bcd_q   <= '0;
         out_ovf_q   <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
         out_blank_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bcd_q   <= out_bcd_d;
         out_ovf_q   <= out_ovf_d;
`ifdef BCD_LZ_BLANK_EN
         out_blank_q <= out_blank_d;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_bcd   = out_bcd_q;
   assign bus.out_ovf   = out_ovf_q;
`ifdef BCD_LZ_BLANK_EN
   assign bus.out_blank = out_blank_q;
`endif

endmodule

`default_nettype wire
